// File: rtl/br_ckpt_ctrl.sv
// Branch checkpoint controller: allocates map-table checkpoint tags,
// tracks outstanding-branch masks and sequences mispredict recovery.
module br_ckpt_ctrl #(
  parameter int NUM_CKPT = 4,
  parameter int CKPT_W   = $clog2(NUM_CKPT),
  parameter int ROB_W    = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                dispatch_en,
  input  logic                dispatch_is_br,
  input  logic [ROB_W-1:0]    dispatch_rob_idx,
  input  logic                resolve_en,
  input  logic [CKPT_W-1:0]   resolve_tag,
  input  logic                resolve_mispredict,
  output logic                ckpt_stall,
  output logic [CKPT_W-1:0]   alloc_tag,
  output logic [NUM_CKPT-1:0] br_mask,
  output logic [NUM_CKPT-1:0] clear_mask,
  output logic                rollback_en,
  output logic [ROB_W-1:0]    rollback_rob_idx,
  output logic [NUM_CKPT-1:0] squash_mask
);

  typedef enum logic {
    IDLE,
    RECOVER
  } state_t;

  state_t              r_state;
  logic [NUM_CKPT-1:0] r_free;
  logic [NUM_CKPT-1:0] r_active;
  logic [NUM_CKPT-1:0] r_dep [NUM_CKPT];
  logic [ROB_W-1:0]    r_rob [NUM_CKPT];
  logic [NUM_CKPT-1:0] r_clear;
  logic                r_rb;
  logic [ROB_W-1:0]    r_rb_idx;
  logic [NUM_CKPT-1:0] r_squash;

  logic [CKPT_W-1:0]   w_alloc_tag;
  logic [NUM_CKPT-1:0] w_alloc_oh;
  logic [NUM_CKPT-1:0] w_tag_oh;
  logic [NUM_CKPT-1:0] w_squash;
  logic [NUM_CKPT-1:0] w_free_n;
  logic [NUM_CKPT-1:0] w_act_n;
  logic                w_stall;
  logic                w_res_valid;
  logic                w_mis;
  logic                w_cor;
  logic                w_alloc_fire;

  assign w_stall     = ~|r_free || (r_state == RECOVER);
  assign w_tag_oh    = NUM_CKPT'(1) << resolve_tag;
  assign w_alloc_oh  = NUM_CKPT'(1) << w_alloc_tag;
  assign w_res_valid = resolve_en && r_active[resolve_tag];
  assign w_mis       = w_res_valid && resolve_mispredict;
  assign w_cor       = w_res_valid && !resolve_mispredict;
  assign w_alloc_fire = dispatch_en && dispatch_is_br &&
                        !w_stall && !w_mis;

  // Lowest free tag; falls back to 0 when nothing is free.
  always_comb begin
    w_alloc_tag = '0;
    for (int i = NUM_CKPT - 1; i >= 0; i--) begin
      if (r_free[i]) w_alloc_tag = CKPT_W'(i);
    end
  end

  // Squash set: the mispredicted tag plus every live branch younger than it.
  always_comb begin
    w_squash = w_tag_oh;
    for (int u = 0; u < NUM_CKPT; u++) begin
      if (r_active[u] && r_dep[u][resolve_tag]) w_squash[u] = 1'b1;
    end
  end

  // Next free/active vectors from allocation, frees and squashes.
  always_comb begin
    w_free_n = r_free;
    w_act_n  = r_active;
    if (w_alloc_fire) begin
      w_free_n = w_free_n & ~w_alloc_oh;
      w_act_n  = w_act_n | w_alloc_oh;
    end
    if (w_cor) begin
      w_free_n = w_free_n | w_tag_oh;
      w_act_n  = w_act_n & ~w_tag_oh;
    end
    if (w_mis) begin
      w_free_n = w_free_n | w_squash;
      w_act_n  = w_act_n & ~w_squash;
    end
  end

  // Recovery FSM, tag bookkeeping and registered event pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_free   <= '1;
      r_active <= '0;
      r_clear  <= '0;
      r_rb     <= 1'b0;
      r_rb_idx <= '0;
      r_squash <= '0;
      for (int u = 0; u < NUM_CKPT; u++) begin
        r_dep[u] <= '0;
        r_rob[u] <= '0;
      end
    end else if (en) begin
      r_state  <= w_mis ? RECOVER : IDLE;
      r_free   <= w_free_n;
      r_active <= w_act_n;
      r_clear  <= w_cor ? w_tag_oh : '0;
      r_rb     <= w_mis;
      r_rb_idx <= w_mis ? r_rob[resolve_tag] : '0;
      r_squash <= w_mis ? w_squash : '0;
      for (int u = 0; u < NUM_CKPT; u++) begin
        if (w_alloc_fire && (CKPT_W'(u) == w_alloc_tag)) begin
          r_dep[u] <= r_active & ~(w_cor ? w_tag_oh : '0);
          r_rob[u] <= dispatch_rob_idx;
        end else if (w_cor) begin
          r_dep[u][resolve_tag] <= 1'b0;
        end
      end
    end
  end

  assign ckpt_stall       = w_stall;
  assign alloc_tag        = w_alloc_tag;
  assign br_mask          = r_active;
  assign clear_mask       = r_clear;
  assign rollback_en      = r_rb;
  assign rollback_rob_idx = r_rb_idx;
  assign squash_mask      = r_squash;

endmodule

// File: tb/tb_br_ckpt_ctrl.sv
// Scoreboard bench for br_ckpt_ctrl: an age-ordered list model predicts
// every cycle's outputs; a monitor pops and compares them.
module tb_br_ckpt_ctrl;

  localparam int N  = 4;
  localparam int CW = 2;
  localparam int RW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          dispatch_en = 1'b0;
  logic          dispatch_is_br = 1'b0;
  logic [RW-1:0] dispatch_rob_idx = '0;
  logic          resolve_en = 1'b0;
  logic [CW-1:0] resolve_tag = '0;
  logic          resolve_mispredict = 1'b0;
  logic          ckpt_stall;
  logic [CW-1:0] alloc_tag;
  logic [N-1:0]  br_mask;
  logic [N-1:0]  clear_mask;
  logic          rollback_en;
  logic [RW-1:0] rollback_rob_idx;
  logic [N-1:0]  squash_mask;

  br_ckpt_ctrl #(.NUM_CKPT(N), .CKPT_W(CW), .ROB_W(RW)) dut (
    .clock(clock),
    .reset(reset),
    .en(en),
    .dispatch_en(dispatch_en),
    .dispatch_is_br(dispatch_is_br),
    .dispatch_rob_idx(dispatch_rob_idx),
    .resolve_en(resolve_en),
    .resolve_tag(resolve_tag),
    .resolve_mispredict(resolve_mispredict),
    .ckpt_stall(ckpt_stall),
    .alloc_tag(alloc_tag),
    .br_mask(br_mask),
    .clear_mask(clear_mask),
    .rollback_en(rollback_en),
    .rollback_rob_idx(rollback_rob_idx),
    .squash_mask(squash_mask)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          stall;
    logic [CW-1:0] tag;
    logic [N-1:0]  bmask;
    logic [N-1:0]  clr;
    logic          rb;
    logic [RW-1:0] rbidx;
    logic [N-1:0]  sq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: live branches kept oldest-first; a mispredict drops the
  // branch and everything after it in the list.
  int            age_q[$];
  logic [RW-1:0] m_rob[N];
  bit            m_rec = 0;
  logic [N-1:0]  m_clr = '0;
  logic [N-1:0]  m_sq = '0;
  bit            m_rb = 0;
  logic [RW-1:0] m_rbidx = '0;

  function automatic int find_pos(int t);
    for (int i = 0; i < age_q.size(); i++)
      if (age_q[i] == t) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] live_mask();
    logic [N-1:0] m = '0;
    foreach (age_q[i]) m[age_q[i]] = 1'b1;
    return m;
  endfunction

  function automatic int lowest_free();
    logic [N-1:0] m = live_mask();
    for (int t = 0; t < N; t++)
      if (!m[t]) return t;
    return 0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t",
               nm, act, req, $time);
    end
  endtask

  task automatic cyc(bit rst, bit e, bit de, bit br, int rob,
                     bit re, int rt, bit rm);
    exp_t x;
    @(posedge clock);
    #2;
    reset = rst;
    en = e;
    dispatch_en = de;
    dispatch_is_br = br;
    dispatch_rob_idx = RW'(rob);
    resolve_en = re;
    resolve_tag = CW'(rt);
    resolve_mispredict = rm;
    if (rst) begin
      age_q.delete();
      m_rec = 0;
      m_clr = '0;
      m_sq = '0;
      m_rb = 0;
      m_rbidx = '0;
    end else if (e) begin
      bit stall = (age_q.size() == N) || m_rec;
      int a = lowest_free();
      int pos = find_pos(rt);
      bit vld = re && (pos >= 0);
      m_clr = '0;
      m_sq = '0;
      m_rb = 0;
      m_rbidx = '0;
      m_rec = 0;
      if (vld && !rm) begin
        age_q.delete(pos);
        m_clr[rt] = 1'b1;
      end else if (vld && rm) begin
        while (age_q.size() > pos) m_sq[age_q.pop_back()] = 1'b1;
        m_rbidx = m_rob[rt];
        m_rb = 1;
        m_rec = 1;
      end
      if (de && br && !stall && !(vld && rm)) begin
        age_q.push_back(a);
        m_rob[a] = RW'(rob);
      end
    end
    x.stall = (age_q.size() == N) || m_rec;
    x.tag   = CW'(lowest_free());
    x.bmask = live_mask();
    x.clr   = m_clr;
    x.rb    = m_rb;
    x.rbidx = m_rbidx;
    x.sq    = m_sq;
    exp_q.push_back(x);
  endtask

  task automatic idle();
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic br(int rob);
    cyc(0, 1, 1, 1, rob, 0, 0, 0);
  endtask

  task automatic rst();
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares the DUT against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ckpt_stall", 32'(ckpt_stall), 32'(e.stall));
        chk("alloc_tag", 32'(alloc_tag), 32'(e.tag));
        chk("br_mask", 32'(br_mask), 32'(e.bmask));
        chk("clear_mask", 32'(clear_mask), 32'(e.clr));
        chk("rollback_en", 32'(rollback_en), 32'(e.rb));
        chk("rollback_rob_idx", 32'(rollback_rob_idx), 32'(e.rbidx));
        chk("squash_mask", 32'(squash_mask), 32'(e.sq));
      end
    end
  end

  initial begin
    rst();
    rst();
    // Fill to stall, then an ignored fifth branch.
    for (int r = 3; r <= 7; r++) br(r);
    // Correct resolve of tag 1, then reuse it.
    cyc(0, 1, 0, 0, 0, 1, 1, 0);
    br(9);
    idle();
    // Mispredict tag 1 with tags 0..2 live.
    rst();
    for (int r = 3; r <= 5; r++) br(r);
    cyc(0, 1, 0, 0, 0, 1, 1, 1);
    idle();
    idle();
    // Mispredict tag 0 while a branch dispatches.
    rst();
    for (int r = 3; r <= 5; r++) br(r);
    cyc(0, 1, 1, 1, 7, 1, 0, 1);
    idle();
    // Back-to-back older mispredicts and a stale resolve.
    rst();
    for (int r = 10; r <= 12; r++) br(r);
    cyc(0, 1, 0, 0, 0, 1, 2, 1);
    cyc(0, 1, 0, 0, 0, 1, 1, 1);
    cyc(0, 1, 0, 0, 0, 1, 0, 1);
    cyc(0, 1, 0, 0, 0, 1, 1, 0);
    idle();
    // Stall with en low, then reset while recovering.
    rst();
    br(20);
    br(21);
    cyc(0, 0, 1, 1, 22, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    cyc(0, 1, 0, 0, 0, 1, 1, 1);
    rst();
    idle();
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < 90),
          ($urandom_range(0, 99) < 70),
          ($urandom_range(0, 99) < 60),
          int'($urandom_range(0, 31)),
          ($urandom_range(0, 99) < 40),
          int'($urandom_range(0, N - 1)),
          ($urandom_range(0, 99) < 25));
    end
    idle();
    repeat (3) @(posedge clock);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
